// File: rtl/pwm_dac_if.sv
// Sample/control bundle between the DDS side and the pwm_dac output stage.
// The master drives the sample word and controls; the slave returns the bitstream.
interface pwm_dac_if #(
  parameter int unsigned MAX_AMP = 8
);
  logic               en;
  logic               mode;
  logic [MAX_AMP-1:0] sample_in;
  logic               pwm_out;
  logic               period_start;

  modport master (
    output en,
    output mode,
    output sample_in,
    input  pwm_out,
    input  period_start
  );

  modport slave (
    input  en,
    input  mode,
    input  sample_in,
    output pwm_out,
    output period_start
  );
endinterface

// File: rtl/pwm_dac.sv
// 1-bit DAC output stage: fixed-period PWM or first-order sigma-delta,
// with the sample word and mode latched once per (2^N - 1)-cycle period.
module pwm_dac #(
  parameter int unsigned MAX_AMP   = 8,
  parameter bit          SIGNED_IN = 1'b0
) (
  input  logic         clk,
  input  logic         res,
  pwm_dac_if.slave     bus
);
  localparam int unsigned N = MAX_AMP;
  localparam logic [N-1:0] S_LAST   = N'((2 ** N) - 2);
  localparam logic [N-1:0] MSB_MASK = SIGNED_IN ? (N'(1) << (N - 1)) : '0;

  logic [N-1:0] s_q, s_d;
  logic [N-1:0] duty_q, duty_d;
  logic         mode_q, mode_d;
  logic [N-1:0] acc_q, acc_d;
  logic         pwm_q, pwm_d;
  logic         start_q, start_d;

  logic         slot0_c;
  logic [N-1:0] d_val_c;
  logic         m_val_c;
  logic [N:0]   sd_sum_c;

  // Two's complement to offset-binary is a single MSB flip.
  assign slot0_c  = (s_q == '0);
  assign d_val_c  = slot0_c ? (bus.sample_in ^ MSB_MASK) : duty_q;
  assign m_val_c  = slot0_c ? bus.mode : mode_q;
  assign sd_sum_c = {1'b0, acc_q} + {1'b0, d_val_c};

  always_comb begin
    s_d     = s_q;
    duty_d  = duty_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    pwm_d   = pwm_q;
    start_d = start_q;

    if (!bus.en) begin
      s_d     = '0;
      acc_d   = '0;
      pwm_d   = 1'b0;
      start_d = 1'b0;
    end else begin
      if (slot0_c) begin
        duty_d = d_val_c;
        mode_d = m_val_c;
      end
      start_d = slot0_c;
      s_d     = (s_q == S_LAST) ? '0 : s_q + N'(1);
      if (!m_val_c) begin
        pwm_d = (s_q < d_val_c);
      end else begin
        // Accumulator free-runs across period boundaries; carry is the output bit.
        acc_d = sd_sum_c[N-1:0];
        pwm_d = sd_sum_c[N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      s_q     <= '0;
      duty_q  <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      pwm_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      duty_q  <= duty_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      pwm_q   <= pwm_d;
      start_q <= start_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = start_q;
endmodule
